// File: rtl/codec_tdm_link.sv
// Codec TDM128 link: bit/frame clock generation, 4-slot serialiser and
// deserialiser, power-down sequencing and a per-frame strobe for the DSP side.
// Handshake: there is no back-pressure. frame_strobe is a one-cycle valid
// that marks new sample_out* values and the consumption of sample_in*.
module codec_tdm_link #(
    parameter int W           = 16,
    parameter int PDN_FRAMES  = 4,
    parameter int WAKE_FRAMES = 8
) (
    input  logic         clk_256fs,
    input  logic         rst,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    output logic         frame_strobe,
    output logic         running,
    output logic         pdn,
    output logic         bick,
    output logic         lrck,
    output logic         sdout,
    input  logic         sdin
);
    localparam int MAX_FRAMES = (PDN_FRAMES > WAKE_FRAMES) ? PDN_FRAMES : WAKE_FRAMES;
    localparam int FRM_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [5:0] W6     = 6'(W);
    localparam logic [4:0] K_LAST = 5'(W - 1);

    typedef enum logic [1:0] {ST_HOLD, ST_WAKE, ST_RUN} state_t;

    state_t             state_q;
    logic [FRM_W-1:0]   frm_q;
    logic               pdn_q;
    logic               running_q;

    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic               bick_q;
    logic               lrck_q;
    logic               sdout_q;
    logic               strobe_q;
    logic [127:0]       tx_q;
    logic [127:0]       tx_load;
    logic [W-1:0]       rx_buf_q [4];
    logic [W-1:0]       out_q [4];

    logic               frame_end;
    logic               run_d;
    logic [1:0]         slot;
    logic [4:0]         k;
    logic [W-1:0]       bit_mask;

    // Left-justify a sample inside its 32-bit slot, zero-filling the tail.
    function automatic logic [31:0] slot_word(input logic [W-1:0] s);
        logic [31:0] t;
        t = '0;
        t[31 -: W] = s;
        return t;
    endfunction

    // Frame position decode: slot = b[6:5], bit-in-slot k = b[4:0].
    assign cnt_d     = cnt_q + 8'd1;
    assign frame_end = (cnt_q == 8'hFF);
    assign slot      = cnt_q[7:6];
    assign k         = cnt_q[5:1];
    assign bit_mask  = W'(1) << (K_LAST - k);

    // RUN as it will be after this edge; the frame that enters RUN is
    // already loaded, strobed and published.
    assign run_d = (state_q == ST_RUN) ||
                   (state_q == ST_WAKE && frame_end && frm_q == FRM_W'(WAKE_FRAMES - 1));

    // Outgoing frame image, slot 0 MSB at bit 127; zeros until RUN.
    assign tx_load = run_d ? {slot_word(sample_in0), slot_word(sample_in1),
                              slot_word(sample_in2), slot_word(sample_in3)} : '0;

    // Startup sequencer: counts frame ends in HOLD, then WAKE, then parks in RUN.
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            frm_q     <= '0;
            pdn_q     <= 1'b0;
            running_q <= 1'b0;
        end else if (frame_end) begin
            unique case (state_q)
                ST_HOLD: begin
                    if (frm_q == FRM_W'(PDN_FRAMES - 1)) begin
                        state_q <= ST_WAKE;
                        frm_q   <= '0;
                        pdn_q   <= 1'b1;
                    end else begin
                        frm_q <= frm_q + 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (frm_q == FRM_W'(WAKE_FRAMES - 1)) begin
                        state_q   <= ST_RUN;
                        frm_q     <= '0;
                        running_q <= 1'b1;
                    end else begin
                        frm_q <= frm_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clock generation, serialiser, deserialiser and sample publication.
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            cnt_q    <= '0;
            bick_q   <= 1'b0;
            lrck_q   <= 1'b1;
            sdout_q  <= 1'b0;
            strobe_q <= 1'b0;
            tx_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                rx_buf_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            bick_q   <= cnt_d[0];
            lrck_q   <= ~cnt_d[7];
            strobe_q <= frame_end && run_d;
            // sdin is taken on the edge that raises bick; only the left-justified
            // W-bit window of each slot is kept.
            if (!cnt_q[0] && ({1'b0, k} < W6)) begin
                rx_buf_q[slot] <= sdin ? (rx_buf_q[slot] | bit_mask)
                                       : (rx_buf_q[slot] & ~bit_mask);
            end
            // sdout changes on bick falling; the frame image is loaded at cnt==255.
            if (frame_end) begin
                sdout_q <= tx_load[127];
                tx_q    <= {tx_load[126:0], 1'b0};
                if (run_d) begin
                    for (int i = 0; i < 4; i++) begin
                        out_q[i] <= rx_buf_q[i];
                    end
                end
            end else if (cnt_q[0]) begin
                sdout_q <= tx_q[127];
                tx_q    <= {tx_q[126:0], 1'b0};
            end
        end
    end

    assign sample_out0  = out_q[0];
    assign sample_out1  = out_q[1];
    assign sample_out2  = out_q[2];
    assign sample_out3  = out_q[3];
    assign frame_strobe = strobe_q;
    assign running      = running_q;
    assign pdn          = pdn_q;
    assign bick         = bick_q;
    assign lrck         = lrck_q;
    assign sdout        = sdout_q;
endmodule

// File: tb/tb_codec_tdm_link.sv
// Bench for codec_tdm_link: startup timing, loopback, bit-accurate sdout,
// codec-driven capture and a mid-run reset.
module tb_codec_tdm_link;
    localparam int W = 16;

    logic           clk_256fs = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   sample_in0 = '0;
    logic [W-1:0]   sample_in1 = '0;
    logic [W-1:0]   sample_in2 = '0;
    logic [W-1:0]   sample_in3 = '0;
    logic [W-1:0]   sample_out0;
    logic [W-1:0]   sample_out1;
    logic [W-1:0]   sample_out2;
    logic [W-1:0]   sample_out3;
    logic           frame_strobe;
    logic           running;
    logic           pdn;
    logic           bick;
    logic           lrck;
    logic           sdout;
    logic           sdin;

    logic           loop_en = 1'b0;
    logic           codec_bit = 1'b0;
    logic [127:0]   codec_frame = '0;
    int unsigned    cyc = 0;
    logic           mon_en = 1'b0;
    logic           epoch1 = 1'b0;
    logic           end_req = 1'b0;
    logic           end_done = 1'b0;
    int             checks = 0;
    int             failures = 0;
    logic [4*W-1:0] exp_q[$];
    logic [127:0]   sd_tab [0:15];

    codec_tdm_link #(.W(W), .PDN_FRAMES(4), .WAKE_FRAMES(8)) dut (
        .clk_256fs    (clk_256fs),
        .rst          (rst),
        .sample_in0   (sample_in0),
        .sample_in1   (sample_in1),
        .sample_in2   (sample_in2),
        .sample_in3   (sample_in3),
        .sample_out0  (sample_out0),
        .sample_out1  (sample_out1),
        .sample_out2  (sample_out2),
        .sample_out3  (sample_out3),
        .frame_strobe (frame_strobe),
        .running      (running),
        .pdn          (pdn),
        .bick         (bick),
        .lrck         (lrck),
        .sdout        (sdout),
        .sdin         (sdin)
    );

    // Clock and reference cycle count (cycles since the last reset edge).
    always #5 clk_256fs = ~clk_256fs;
    always @(posedge clk_256fs) cyc <= rst ? 0 : cyc + 1;

    assign sdin = loop_en ? sdout : codec_bit;

    // Codec model: presents bit b of codec_frame, slot 0 MSB first.
    initial begin
        forever begin
            @(negedge clk_256fs);
            codec_bit = codec_frame[127 - int'(cyc[7:1])];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: checks every cycle on the falling edge.
    initial begin
        logic [4*W-1:0] hold_exp;
        logic [3:0]     tim_exp;
        logic           sd_exp;
        int             frame;
        int             b;
        hold_exp = '0;
        forever begin
            @(negedge clk_256fs);
            if (mon_en) begin
                tim_exp = {cyc[0], ~cyc[7], cyc >= 1024, cyc >= 3072};
                chk("timing", {60'b0, bick, lrck, pdn, running}, {60'b0, tim_exp});
                chk("strobe", {63'b0, frame_strobe}, {63'b0, (cyc >= 3072 && cyc[7:0] == 8'd0)});
                if (frame_strobe) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_empty cyc=%0d act=strobe exp=no_strobe", cyc);
                    end else begin
                        hold_exp = exp_q.pop_front();
                    end
                end
                chk("sample_out", {sample_out0, sample_out1, sample_out2, sample_out3},
                    (cyc < 3072) ? 64'h0 : hold_exp);
                frame = int'(cyc >> 8);
                b     = int'(cyc[7:1]);
                sd_exp = (epoch1 || frame > 15) ? 1'b0 : sd_tab[frame][127 - b];
                chk("sdout", {63'b0, sdout}, {63'b0, sd_exp});
                if (end_req && !end_done) begin
                    chk("sb_drain", 64'(exp_q.size()), 64'd0);
                    end_done = 1'b1;
                end
            end
        end
    end

    task automatic goto(input int f, input int c);
        int t;
        t = f * 256 + c;
        while (int'(cyc) < t) @(negedge clk_256fs);
    endtask

    // Stimulus.
    initial begin
        for (int i = 0; i < 16; i++) sd_tab[i] = '0;
        sd_tab[12] = {32'h8001_0000, 32'h7FFE_0000, 32'h0000_0000, 32'hFFFF_0000};
        sd_tab[13] = {32'h8001_0000, 32'hA5C3_0000, 32'h0000_0000, 32'hFFFF_0000};
        sd_tab[14] = {32'h2222_0000, 32'hA5C3_0000, 32'h0000_0000, 32'hFFFF_0000};
        sd_tab[15] = {32'h2222_0000, 32'hA5C3_0000, 32'h0000_0000, 32'hFFFF_0000};

        exp_q.push_back({16'h0000, 16'h0000, 16'h0000, 16'h0000});
        exp_q.push_back({16'h8001, 16'h7FFE, 16'h0000, 16'hFFFF});
        exp_q.push_back({16'h8001, 16'hA5C3, 16'h0000, 16'hFFFF});
        exp_q.push_back({16'h2222, 16'hA5C3, 16'h0000, 16'hFFFF});
        exp_q.push_back({16'h0000, 16'h0000, 16'h0000, 16'h1234});
        exp_q.push_back({16'h0000, 16'h0000, 16'h0000, 16'h0000});
        exp_q.push_back({16'hFFFF, 16'h0000, 16'h8000, 16'h0000});

        @(negedge clk_256fs);
        mon_en = 1'b1;
        @(negedge clk_256fs);
        rst = 1'b0;

        goto(11, 0);
        loop_en    = 1'b1;
        sample_in0 = 16'h8001;
        sample_in1 = 16'h7FFE;
        sample_in2 = 16'h0000;
        sample_in3 = 16'hFFFF;
        goto(12, 1);
        sample_in1 = 16'hA5C3;
        goto(13, 100);
        sample_in0 = 16'h1111;
        goto(13, 200);
        sample_in0 = 16'h2222;
        goto(14, 255);
        loop_en     = 1'b0;
        codec_frame = {96'h0, 32'h1234_FFFF};
        goto(15, 255);
        sample_in0 = '0;
        sample_in1 = '0;
        sample_in2 = '0;
        sample_in3 = '0;
        goto(16, 130);
        rst         = 1'b1;
        epoch1      = 1'b1;
        codec_frame = '0;
        @(negedge clk_256fs);
        rst = 1'b0;
        goto(11, 255);
        codec_frame = {32'hFFFF_0001, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        goto(13, 8);
        end_req = 1'b1;
        repeat (3) @(negedge clk_256fs);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
